packet_buffer_mem: RTL
======================

// Module: packet_buffer_mem
// PURPOSE
//  Storage end of the agent->buffer mux path: one ping/pang/pong packet buffer.
//  Accepts the routed bundle {addr, wr_data, wr_en, bytes_inc, reset_len, rd_en}.
//  Returns {rd_data, rd_data_vld, packet_len} to whichever agent is selected.
//  Serves as the snooper write target, the CPU read source and the forwarder read source.
//  Three instances sit behind the muxes inside each packetfilter core.
// PARAMETERS
//  ADDR_WIDTH  9   word address width; depth = 2**ADDR_WIDTH words
//  DATA_WIDTH  64  word width in bits
//  INC_WIDTH   8   width of bytes_inc
//  PLEN_WIDTH  32  width of packet_len
//  RD_LAT      2   read latency in cycles, rd_en -> rd_data_vld; legal values 1 or 2
// PORTS
//  clk          in   1           clock; all logic on rising edge
//  rst          in   1           synchronous, active-high reset
//  addr         in   ADDR_WIDTH  word address, shared by reads and writes
//  wr_data      in   DATA_WIDTH  write data
//  wr_en        in   1           write mem[addr] <= wr_data this edge
//  bytes_inc    in   INC_WIDTH   valid bytes in this write; added to packet_len
//  reset_len    in   1           clear packet_len (buffer released)
//  rd_en        in   1           read request for mem[addr]
//  rd_data      out  DATA_WIDTH  read data
//  rd_data_vld  out  1           one-cycle pulse per accepted rd_en
//  packet_len   out  PLEN_WIDTH  accumulated byte count of the stored packet
// BEHAVIOUR
//  Reset: rd_data=0, rd_data_vld=0, packet_len=0; read pipeline flushed; RAM contents kept.
//  rst has priority over every other input on the same edge.
//  Write: wr_en=1 at edge N -> mem[addr] updated at edge N.
//   - bytes_inc applies only when wr_en=1.
//  packet_len is a register; the next value is:
//   - reset_len=1: (wr_en ? bytes_inc : 0). Reset then add; same-cycle write is not lost.
//   - reset_len=0, wr_en=1: packet_len + bytes_inc, zero-extended.
//     Saturates at 2**PLEN_WIDTH-1, no wrap.
//   - otherwise: hold.
//  Read: rd_en=1 at edge N -> rd_data and rd_data_vld=1 at edge N+RD_LAT.
//   - Fully pipelined: one read accepted per cycle, no stalls, no backpressure.
//   - rd_data holds its last value while rd_data_vld=0.
//  A single addr serves both ports. With rd_en=wr_en=1 in the same cycle:
//   - the write commits;
//   - the read returns the OLD word (read-first).
//  A reset asserted while reads are in flight squashes them; no vld is produced after rst.
//  Address wraps naturally modulo depth. No bounds checks; out-of-range is impossible by width.
//  No state machine. Control is a RD_LAT-deep valid shift register plus the length accumulator.
// STRUCTURE
//  Shared header bpf_defs.vh: default widths, RD_LAT legal-value check.
//   - Also defines the bundle-order macros for to_buf {addr,wr_data,wr_en,bytes_inc,reset_len,rd_en}.
//   - And for from_buf {rd_data,rd_data_vld,packet_len}, shared with muxes.
//  Sub-module sdp_bram: simple dual-port RAM, read-first, with an optional output register.
//   - The output register is enabled when RD_LAT=2, for BRAM inference.
//   - This top holds the valid pipeline, the length accumulator and reset handling.
// TESTING
//  1. rst=1 for 2 cycles with rd_en=1 -> rd_data_vld=0, packet_len=0 throughout and after.
//  2. Write words 0..7 with data 'hA0+i and bytes_inc=8, then read 0..7 back-to-back:
//     - vld high 8 cycles starting RD_LAT after the first rd_en;
//     - data returns 'hA0..'hA7 in order;
//     - packet_len=64.
//  3. addr=5 with mem[5]='h11; same cycle wr_en=1, wr_data='h22, rd_en=1:
//     - rd_data='h11;
//     - a following read of 5 returns 'h22.
//  4. packet_len=100; same cycle reset_len=1, wr_en=1, bytes_inc=6 -> packet_len=6 next cycle.
//  5. packet_len=2**32-3 with bytes_inc=8 write -> packet_len=2**32-1, then holds on more writes.
//  6. Issue rd_en at N and N+1, rst at N+1 -> no rd_data_vld pulses at all.
//     Run with both RD_LAT=1 and RD_LAT=2.

Source files
------------

// File: rtl/packet_buffer_mem_pkg.sv
// Shared defaults for the packet buffer path: widths, read-latency legality
// and the to_buf / from_buf bundle layouts used by the agent<->buffer muxes.
package packet_buffer_mem_pkg;

  localparam int DEF_ADDR_WIDTH = 9;
  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_INC_WIDTH  = 8;
  localparam int DEF_PLEN_WIDTH = 32;
  localparam int DEF_RD_LAT     = 2;

  // Bundle field order, MSB first:
  //   to_buf   = {addr, wr_data, wr_en, bytes_inc, reset_len, rd_en}
  //   from_buf = {rd_data, rd_data_vld, packet_len}
  typedef struct packed {
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_DATA_WIDTH-1:0] wr_data;
    logic                      wr_en;
    logic [DEF_INC_WIDTH-1:0]  bytes_inc;
    logic                      reset_len;
    logic                      rd_en;
  } to_buf_t;

  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] rd_data;
    logic                      rd_data_vld;
    logic [DEF_PLEN_WIDTH-1:0] packet_len;
  } from_buf_t;

  function automatic bit rd_lat_legal(input int lat);
    return (lat == 1) || (lat == 2);
  endfunction

  function automatic int to_buf_width(input int aw, input int dw, input int iw);
    return aw + dw + 1 + iw + 1 + 1;
  endfunction

  function automatic int from_buf_width(input int dw, input int pw);
    return dw + 1 + pw;
  endfunction

endpackage

// File: rtl/packet_buffer_mem_sdp_bram.sv
// Simple dual-port RAM, read-first, registered read with an optional second
// output register so the tools can pack both stages into the block RAM.
module packet_buffer_mem_sdp_bram
  import packet_buffer_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter bit OUT_REG    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  input  logic                  i_oce,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
  logic [DATA_WIDTH-1:0] r_rd_stage;

  // Contents are deliberately not reset: a buffer release keeps stale data.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Non-blocking read of the array gives read-first on a same-address write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_stage <= '0;
    end else if (i_re) begin
      r_rd_stage <= r_mem[i_raddr];
    end
  end

  generate
    if (OUT_REG) begin : g_out_reg
      logic [DATA_WIDTH-1:0] r_rd_out;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_rd_out <= '0;
        end else if (i_oce) begin
          r_rd_out <= r_rd_stage;
        end
      end

      assign o_rdata = r_rd_out;
    end else begin : g_no_out_reg
      logic w_unused_oce;
      assign w_unused_oce = i_oce;
      assign o_rdata      = r_rd_stage;
    end
  endgenerate

endmodule

// File: rtl/packet_buffer_mem.sv
// One ping/pang/pong packet buffer: word storage, fixed-latency read pipeline
// with squash-on-reset, and a saturating byte-length accumulator.
module packet_buffer_mem
  import packet_buffer_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int INC_WIDTH  = DEF_INC_WIDTH,
  parameter int PLEN_WIDTH = DEF_PLEN_WIDTH,
  parameter int RD_LAT     = DEF_RD_LAT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  input  logic [INC_WIDTH-1:0]  bytes_inc,
  input  logic                  reset_len,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_data_vld,
  output logic [PLEN_WIDTH-1:0] packet_len
);

  generate
    if (!rd_lat_legal(RD_LAT)) begin : g_bad_rd_lat
      $error("packet_buffer_mem: RD_LAT must be 1 or 2");
    end
    if (INC_WIDTH > PLEN_WIDTH) begin : g_bad_inc_width
      $error("packet_buffer_mem: INC_WIDTH must not exceed PLEN_WIDTH");
    end
  endgenerate

  logic                  w_wr_en;
  logic                  w_rd_en;
  logic [RD_LAT-1:0]     r_vld_pipe;
  logic [PLEN_WIDTH:0]   w_inc_ext;
  logic [PLEN_WIDTH:0]   w_len_sum;
  logic [PLEN_WIDTH-1:0] w_len_sat;
  logic [PLEN_WIDTH-1:0] w_len_next;
  logic [PLEN_WIDTH-1:0] r_len;

  // Reset outranks every request on the same edge.
  assign w_wr_en = wr_en & ~rst;
  assign w_rd_en = rd_en & ~rst;

  packet_buffer_mem_sdp_bram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .OUT_REG    (RD_LAT == 2)
  ) u_bram (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_wr_en),
    .i_waddr (addr),
    .i_wdata (wr_data),
    .i_re    (w_rd_en),
    .i_raddr (addr),
    .i_oce   (r_vld_pipe[0]),
    .o_rdata (rd_data)
  );

  genvar gi;
  generate
    for (gi = 0; gi < RD_LAT; gi++) begin : g_vld_pipe
      always_ff @(posedge clk) begin
        if (rst) begin
          r_vld_pipe[gi] <= 1'b0;
        end else if (gi == 0) begin
          r_vld_pipe[gi] <= rd_en;
        end else begin
          r_vld_pipe[gi] <= r_vld_pipe[(gi > 0) ? gi - 1 : 0];
        end
      end
    end
  endgenerate

  // Masking with rst keeps a read that would surface during the reset cycle
  // from ever being seen downstream.
  assign rd_data_vld = r_vld_pipe[RD_LAT-1] & ~rst;

  assign w_inc_ext = {{(PLEN_WIDTH + 1 - INC_WIDTH){1'b0}}, bytes_inc};
  assign w_len_sum = {1'b0, r_len} + w_inc_ext;
  assign w_len_sat = w_len_sum[PLEN_WIDTH] ? {PLEN_WIDTH{1'b1}} : w_len_sum[PLEN_WIDTH-1:0];

  // A release and a write in the same cycle restart the count at this write.
  always_comb begin
    w_len_next = r_len;
    if (reset_len) begin
      w_len_next = wr_en ? w_inc_ext[PLEN_WIDTH-1:0] : '0;
    end else if (wr_en) begin
      w_len_next = w_len_sat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_len <= '0;
    end else begin
      r_len <= w_len_next;
    end
  end

  assign packet_len = r_len;

endmodule
